// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with a 2-entry valid/ready output buffer.
// Decodes instr[31:21], extends the immediate to N bits and tags its format.
// Illegal opcodes are flagged per entry and counted in a saturating counter.
// Optional macro IMM_GEN_BR_SHIFT_EN: CB/B immediates are pre-scaled to bytes.
module imm_gen_pipe #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     imm,
  output logic [2:0]       fmt,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned FMT_W = 3;
  localparam int unsigned ENT_W = N + FMT_W + 1;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_D    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_CB   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_IW   = 3'd5;

  // Buffer entries are packed as {imm, fmt, err}
  logic [ENT_W-1:0] head, head_d;
  logic [ENT_W-1:0] tail, tail_d;
  logic [1:0]       count, count_d;
  logic [CNT_W-1:0] err_cnt_d;

  logic [63:0]      dec_imm64;
  logic [63:0]      cb_imm64;
  logic [63:0]      b_imm64;
  logic [FMT_W-1:0] dec_fmt;
  logic             dec_err;
  logic [ENT_W-1:0] dec_ent;
  logic             push;
  logic             pop;

  // Opcode decode and immediate extraction, computed at 64 bits then truncated
  always_comb begin
    dec_imm64 = 64'd0;
    dec_fmt   = FMT_NONE;
    dec_err   = 1'b0;
`ifdef IMM_GEN_BR_SHIFT_EN
    cb_imm64  = 64'($signed(instr[23:5])) << 2;
    b_imm64   = 64'($signed(instr[25:0])) << 2;
`else
    cb_imm64  = 64'($signed(instr[23:5]));
    b_imm64   = 64'($signed(instr[25:0]));
`endif
    casez (instr[31:21])
      11'b11111000010, 11'b11111000000: begin
        dec_fmt   = FMT_D;
        dec_imm64 = 64'($signed(instr[20:12]));
      end
      11'b10110100???, 11'b10110101???, 11'b01010100???: begin
        dec_fmt   = FMT_CB;
        dec_imm64 = cb_imm64;
      end
      11'b000101?????, 11'b100101?????: begin
        dec_fmt   = FMT_B;
        dec_imm64 = b_imm64;
      end
      11'b1001000100?, 11'b1101000100?: begin
        dec_fmt   = FMT_I;
        dec_imm64 = 64'(instr[21:10]);
      end
      11'b110100101??: begin
        // A 32-bit result cannot hold a halfword shifted by 32 or 48
        if ((N < 64) && instr[22]) begin
          dec_err = 1'b1;
        end else begin
          dec_fmt   = FMT_IW;
          dec_imm64 = 64'(instr[20:5]) << {instr[22:21], 4'b0000};
        end
      end
      default: dec_err = 1'b1;
    endcase
    dec_ent = {N'(dec_imm64), dec_fmt, dec_err};
  end

  // Buffer next state: head register feeds the outputs, tail holds the second entry
  always_comb begin
    count_d   = count;
    head_d    = head;
    tail_d    = tail;
    err_cnt_d = err_cnt;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready;
    if (flush) begin
      count_d = 2'd0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_d  = dec_ent;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = dec_ent;
          end else if (push) begin
            tail_d  = dec_ent;
            count_d = 2'd2;
          end else if (pop) begin
            head_d  = '0;
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail;
            tail_d  = '0;
            count_d = 2'd1;
          end
        end
        default: begin
          head_d  = '0;
          tail_d  = '0;
          count_d = 2'd0;
        end
      endcase
    end
    if (push && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt + CNT_W'(1);
    end
  end

  // State and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 2'd0;
      head      <= '0;
      tail      <= '0;
      err_cnt   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count     <= count_d;
      head      <= head_d;
      tail      <= tail_d;
      err_cnt   <= err_cnt_d;
      out_valid <= (count_d != 2'd0);
      in_ready  <= (count_d != 2'd2);
    end
  end

  assign imm = head[ENT_W-1 -: N];
  assign fmt = head[FMT_W:1];
  assign err = head[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: N=64 main instance plus an N=32 instance on the same inputs.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid, err;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic [7:0]  err_cnt;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  err_cnt32;

  int checks = 0;
  int errors = 0;

`ifdef IMM_GEN_BR_SHIFT_EN
  localparam logic [63:0] B_ALL1  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] CB_ALL1 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] CB_TWO  = 64'd8;
`else
  localparam logic [63:0] B_ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CB_ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CB_TWO  = 64'd2;
`endif

  imm_gen_pipe #(.N(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt),
    .err(err), .err_cnt(err_cnt)
  );

  imm_gen_pipe #(.N(32), .CNT_W(8)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
    .err(err32), .err_cnt(err_cnt32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word for one edge with out_ready high, then check the head
  task automatic one(input string tag, input logic [31:0] w, input logic [63:0] e_imm,
                     input logic [2:0] e_fmt, input logic e_err);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".imm"}, imm, e_imm);
    chk({tag, ".fmt"}, 64'(fmt), 64'(e_fmt));
    chk({tag, ".err"}, 64'(err), 64'(e_err));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.imm", imm, 64'd0);
    chk("rst.fmt", 64'(fmt), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    one("ldur", 32'hF85F8041, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0);
    one("stur", 32'hF80083E0, 64'd8, 3'd1, 1'b0);
    one("movz", 32'hD2C24680, 64'h0000_1234_0000_0000, 3'd5, 1'b0);
    chk("movz32.fmt", 64'(fmt32), 64'd0);
    chk("movz32.err", 64'(err32), 64'd1);
    chk("movz32.cnt", 64'(err_cnt32), 64'd1);
    chk("movz64.cnt", 64'(err_cnt), 64'd0);
    one("b", 32'h17FFFFFF, B_ALL1, 3'd3, 1'b0);
    one("cbz", 32'hB4FFFFE0, CB_ALL1, 3'd2, 1'b0);
    one("bcond", 32'h54000040, CB_TWO, 3'd2, 1'b0);
    one("addi", 32'h913FFC41, 64'hFFF, 3'd4, 1'b0);
    one("subi", 32'hD1000421, 64'd1, 3'd4, 1'b0);
    one("ill", 32'h00000000, 64'd0, 3'd0, 1'b1);
    chk("ill.cnt", 64'(err_cnt), 64'd1);
    @(posedge clk); #1;
    chk("drain.valid", 64'(out_valid), 64'd0);
    chk("drain.imm", imm, 64'd0);

    // Backpressure: fill both entries, hold the third word at the source
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h913FFC41;
    @(posedge clk); #1;
    chk("bp1.ready", 64'(in_ready), 64'd1);
    instr = 32'hF85F8041;
    @(posedge clk); #1;
    chk("bp2.ready", 64'(in_ready), 64'd0);
    chk("bp2.imm", imm, 64'hFFF);
    instr = 32'h17FFFFFF;
    @(posedge clk); #1;
    chk("bp3.ready", 64'(in_ready), 64'd0);
    chk("bp3.valid", 64'(out_valid), 64'd1);
    chk("bp3.imm", imm, 64'hFFF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp4.ready", 64'(in_ready), 64'd1);
    chk("bp4.imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp5.imm", imm, B_ALL1);
    chk("bp5.fmt", 64'(fmt), 64'd3);
    @(posedge clk); #1;
    chk("bp6.valid", 64'(out_valid), 64'd0);

    // Flush with a simultaneous illegal word: nothing accepted, counter untouched
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h913FFC41;
    @(posedge clk); #1;
    instr = 32'hD1000421;
    @(posedge clk); #1;
    chk("fl0.ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    instr = 32'h00000000;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1.valid", 64'(out_valid), 64'd0);
    chk("fl1.ready", 64'(in_ready), 64'd1);
    chk("fl1.imm", imm, 64'd0);
    chk("fl1.cnt", 64'(err_cnt), 64'd1);
    @(posedge clk); #1;
    chk("fl2.valid", 64'(out_valid), 64'd0);

    // Stream 300 illegal words; counter saturates
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h00000000;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      chk("str.fmt", 64'(fmt), 64'd0);
      chk("str.err", 64'(err), 64'd1);
    end
    chk("str.cnt", 64'(err_cnt), 64'd255);
    chk("str.cnt32", 64'(err_cnt32), 64'd255);

    // Reset mid-stream, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.ready", 64'(in_ready), 64'd1);
    chk("arst.imm", imm, 64'd0);
    chk("arst.fmt", 64'(fmt), 64'd0);
    chk("arst.err", 64'(err), 64'd0);
    chk("arst.cnt", 64'(err_cnt), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the LEGv8 datapath. Decodes the opcode field instr[31:21], extracts and sign- or zero-extends the immediate to N bits, and tags it with a format code. Results pass through a 2-entry valid/ready output buffer so the block can sit between fetch/decode pipeline registers under backpressure. Unrecognised opcodes are flagged and counted.

## Interface
- N, 64, result width; legal values 32 or 64.
- CNT_W, 8, width of the saturating illegal-opcode counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; empties the buffer.
- in_valid  in  1  instr is presented.
- in_ready  out  1  buffer can accept; registered.
- instr  in  32  instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- imm  out  N  extended immediate of the head entry.
- fmt  out  3  format of the head entry: 0 NONE, 1 D, 2 CB, 3 B, 4 I, 5 IW.
- err  out  1  head entry was illegal.
- err_cnt  out  CNT_W  accepted illegal instructions; saturating.

## Operation
- Decode on instr[31:21], where x is a don't-care bit:
  - 11111000010 (LDUR) or 11111000000 (STUR): fmt D, imm = sext(instr[20:12]).
  - 10110100xxx (CBZ), 10110101xxx (CBNZ) or 01010100xxx (B.cond): fmt CB, imm = sext(instr[23:5]).
  - 000101xxxxx (B) or 100101xxxxx (BL): fmt B, imm = sext(instr[25:0]).
  - 1001000100x (ADDI) or 1101000100x (SUBI): fmt I, imm = zext(instr[21:10]).
  - 110100101xx (MOVZ): fmt IW, imm = zext(instr[20:5]) << (16*instr[22:21]).
  - Anything else: fmt NONE, imm = 0, err = 1.
- With N=32, MOVZ with hw = instr[22:21] ≥ 2 is illegal: fmt NONE, imm 0, err 1.
- Sign extension replicates the field MSB up to bit N-1.
- Buffer: 2-entry FIFO holding {imm, fmt, err}, with count in 0..2.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Push and pop together at count 1: count stays 1, and the new entry becomes head on the next cycle.
  - in_ready = (count < 2) as registered state; no push is possible at count 2.
  - out_valid = (count ≠ 0). imm/fmt/err show the head entry, or 0 when count is 0.
  - Entries leave in acceptance order.
- err_cnt increments by 1 on each push of an illegal entry and holds at 2^CNT_W−1.
- flush: count goes to 0 at the next edge and in_valid is ignored that cycle. err_cnt is unaffected, and a push suppressed by flush is not counted.

## Timing
- Latency: instr accepted at edge t appears on imm/fmt/err with out_valid=1 after edge t (1 cycle) when the buffer was empty.
- Throughput: 1 per cycle when out_ready is held high.
- After reset: out_valid 0, in_ready 1, imm 0, fmt 0, err 0, err_cnt 0, count 0.
- Reset asserted mid-operation discards buffered entries immediately, without waiting for clk.
- in_ready deasserts at the edge where count reaches 2. It reasserts at the edge following the first pop.
- out_valid/imm must stay stable while out_valid && !out_ready.

## Configuration
- IMM_GEN_BR_SHIFT_EN defined: CB and B immediates are output pre-scaled to bytes, as sext(field) << 2, truncated to N bits.
- IMM_GEN_BR_SHIFT_EN undefined: CB and B immediates are raw word offsets. D, I and IW formats are unaffected in both cases.

## Test plan
- LDUR X1,[X2,#-8]: 0xF85F8041 with out_ready=1 -> one cycle later imm=0xFFFFFFFFFFFFFFF8, fmt=1, err=0.
- MOVZ X0,#0x1234,LSL#32: 0xD2C24680 -> imm=0x0000123400000000, fmt=5. With N=32 the same word gives fmt=0, err=1, err_cnt=1.
- B with imm26 all ones (0x17FFFFFF) -> imm=0xFFFFFFFFFFFFFFFF, fmt=3. With IMM_GEN_BR_SHIFT_EN defined -> 0xFFFFFFFFFFFFFFFC.
- Backpressure: out_ready=0, push ADDI 0x913FFC41, then LDUR, then B.
  - in_ready must be 0 after the 2nd accept, and the 3rd word is held by the source.
  - Raise out_ready -> imm 0xFFF, then 0xFFFFFFFFFFFFFFF8, then B's immediate, in order.
- Push 2 entries, assert flush together with in_valid -> out_valid=0 next cycle, in_ready=1, nothing accepted.
- Push 300 words of 0x00000000 -> each output has fmt=0, err=1, and err_cnt ends at 255. Assert reset mid-stream -> all outputs return to reset values without waiting for clk.
